// File: rtl/pipeline_pkg.sv
// Shared definitions for the instruction fetch path: state encoding,
// address width and the default halt opcode.
package pipeline_pkg;

   localparam int PC_W = 16;
   localparam logic [3:0] HALT_OP_DEFAULT = 4'hF;

   typedef enum logic [1:0] {
      FILL = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2,
      HALT = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding a returned instruction word and its pc
// while decode is stalled. Flush beats load, load beats drain.
module fetch_skid_buf
   import pipeline_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            i_load,
   input  logic            i_drain,
   input  logic            i_flush,
   input  logic [PC_W-1:0] i_data,
   input  logic [PC_W-1:0] i_pc,
   output logic            o_valid,
   output logic [PC_W-1:0] o_data,
   output logic [PC_W-1:0] o_pc
);

   logic            r_valid;
   logic [PC_W-1:0] r_data;
   logic [PC_W-1:0] r_pc;

   // Capture, release or discard the single buffered entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_pc    <= '0;
      end else if (i_flush) begin
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_data  <= i_data;
         r_pc    <= i_pc;
      end else if (i_drain) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;
   assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: issues one read per cycle from a registered
// pc, presents returned words to decode, absorbs a decode stall through a
// one-entry skid buffer, handles redirects and a halt opcode.
// Optional feature: define FETCH_PERF_EN to add the fetch_count output.
module fetch_sequencer
   import pipeline_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC = 16'h0000,
   parameter int unsigned     PC_STEP  = 2,
   parameter logic [3:0]      HALT_OP  = HALT_OP_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            redirect,
   input  logic [PC_W-1:0] redirect_pc,
   output logic [PC_W-1:0] imem_addr,
   input  logic [PC_W-1:0] imem_rdata,
   output logic [PC_W-1:0] instr,
   output logic [PC_W-1:0] instr_pc,
   output logic            instr_valid,
   output logic            halted
`ifdef FETCH_PERF_EN
   ,
   output logic [PC_W-1:0] fetch_count
`endif
);

   localparam logic [PC_W-1:0] STEP = PC_W'(PC_STEP);

   fetch_state_e    r_state, w_next_state;
   logic [PC_W-1:0] r_pc;
   logic            r_inf_vld;
   logic [PC_W-1:0] r_inf_pc;
   logic [PC_W-1:0] r_instr;
   logic [PC_W-1:0] r_instr_pc;
   logic            r_instr_valid;

   logic            w_hold_out, w_is_halt;
   logic            w_issue, w_out_ld, w_out_clr, w_sel_skid;
   logic            w_skid_load, w_skid_drain, w_skid_flush;
   logic            w_skid_vld;
   logic [PC_W-1:0] w_skid_data, w_skid_pc;
   logic            w_src_vld;
   logic [PC_W-1:0] w_src_data, w_src_pc;

   assign w_hold_out = r_instr_valid & stall;
   assign w_is_halt  = r_instr_valid & ~stall & (r_instr[15:12] == HALT_OP);

   fetch_skid_buf u_skid (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_skid_load),
      .i_drain (w_skid_drain),
      .i_flush (w_skid_flush),
      .i_data  (imem_rdata),
      .i_pc    (r_inf_pc),
      .o_valid (w_skid_vld),
      .o_data  (w_skid_data),
      .o_pc    (w_skid_pc)
   );

   // Next state and per-cycle fetch/output/skid controls; redirect wins over all.
   always_comb begin
      w_next_state = r_state;
      w_issue      = 1'b0;
      w_out_ld     = 1'b0;
      w_out_clr    = 1'b0;
      w_sel_skid   = 1'b0;
      w_skid_load  = 1'b0;
      w_skid_drain = 1'b0;
      w_skid_flush = 1'b0;
      if (redirect) begin
         w_next_state = FILL;
         w_out_clr    = 1'b1;
         w_skid_flush = 1'b1;
      end else begin
         case (r_state)
            FILL: begin
               w_issue      = 1'b1;
               w_out_ld     = 1'b1;
               w_next_state = RUN;
            end
            RUN: begin
               if (w_hold_out) begin
                  w_skid_load  = r_inf_vld;
                  w_next_state = HOLD;
               end else if (w_is_halt) begin
                  w_out_clr    = 1'b1;
                  w_skid_flush = 1'b1;
                  w_next_state = HALT;
               end else begin
                  w_issue  = 1'b1;
                  w_out_ld = 1'b1;
               end
            end
            HOLD: begin
               if (w_is_halt) begin
                  w_out_clr    = 1'b1;
                  w_skid_flush = 1'b1;
                  w_next_state = HALT;
               end else if (!w_hold_out) begin
                  w_issue      = 1'b1;
                  w_out_ld     = 1'b1;
                  w_sel_skid   = 1'b1;
                  w_skid_drain = 1'b1;
                  w_next_state = RUN;
               end
            end
            HALT: begin
               w_next_state = HALT;
            end
            default: begin
               w_next_state = FILL;
            end
         endcase
      end
   end

   // Source for the output register: skid entry on stall release, else the returning word.
   always_comb begin
      w_src_vld  = r_inf_vld;
      w_src_data = imem_rdata;
      w_src_pc   = r_inf_pc;
      if (w_sel_skid) begin
         w_src_vld  = w_skid_vld;
         w_src_data = w_skid_data;
         w_src_pc   = w_skid_pc;
      end
   end

   // State, fetch pc and in-flight request tracking.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= FILL;
         r_pc      <= RESET_PC;
         r_inf_vld <= 1'b0;
         r_inf_pc  <= '0;
      end else begin
         r_state   <= w_next_state;
         r_inf_vld <= w_issue;
         if (redirect) begin
            r_pc <= redirect_pc;
         end else if (w_issue) begin
            r_pc     <= r_pc + STEP;
            r_inf_pc <= r_pc;
         end
      end
   end

   // Instruction output register presented to decode.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_instr       <= '0;
         r_instr_pc    <= '0;
         r_instr_valid <= 1'b0;
      end else if (w_out_clr) begin
         r_instr_valid <= 1'b0;
      end else if (w_out_ld) begin
         r_instr_valid <= w_src_vld;
         if (w_src_vld) begin
            r_instr    <= w_src_data;
            r_instr_pc <= w_src_pc;
         end
      end
   end

`ifdef FETCH_PERF_EN
   logic [PC_W-1:0] r_fetch_count;

   // Count instructions accepted by decode; wraps naturally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fetch_count <= '0;
      end else if (r_instr_valid && !stall && !redirect) begin
         r_fetch_count <= r_fetch_count + 1'b1;
      end
   end

   assign fetch_count = r_fetch_count;
`endif

   assign imem_addr   = r_pc;
   assign instr       = r_instr;
   assign instr_pc    = r_instr_pc;
   assign instr_valid = r_instr_valid;
   assign halted      = (r_state == HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a vector table for the main run
// (fill, stall/skid, redirect in HOLD, stall while empty) plus hand-written
// sequences for reset in HOLD, halt/restart and pc wrap on a second instance.
module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [15:0] redirect_pc = 16'h0000;
   logic [15:0] imem_addr, imem_rdata = 16'h0000;
   logic [15:0] instr, instr_pc;
   logic        instr_valid, halted;
   logic        halt_en = 1'b0;

   logic        stall2 = 1'b0;
   logic        redirect2 = 1'b0;
   logic [15:0] redirect_pc2 = 16'h0000;
   logic [15:0] imem_addr2, imem_rdata2 = 16'h0000;
   logic [15:0] instr2, instr_pc2;
   logic        instr_valid2, halted2;
`ifdef FETCH_PERF_EN
   logic [15:0] fcount, fcount2;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   fetch_sequencer dut (
      .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
      .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .halted(halted)
`ifdef FETCH_PERF_EN
      , .fetch_count(fcount)
`endif
   );

   fetch_sequencer #(.RESET_PC(16'hFFFC)) dut2 (
      .clk(clk), .rst(rst), .stall(stall2), .redirect(redirect2),
      .redirect_pc(redirect_pc2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
      .instr(instr2), .instr_pc(instr_pc2), .instr_valid(instr_valid2), .halted(halted2)
`ifdef FETCH_PERF_EN
      , .fetch_count(fcount2)
`endif
   );

   function automatic logic [15:0] mem_word(input logic [15:0] a, input logic hen);
      if (hen && a == 16'h0006) return 16'hF000;
      return {4'h1, a[11:0]};
   endfunction

   // Synchronous instruction memories: data one cycle after address.
   always @(posedge clk) begin
      imem_rdata  <= mem_word(imem_addr, halt_en);
      imem_rdata2 <= mem_word(imem_addr2, 1'b0);
   end

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        stall;
      logic        redir;
      logic [15:0] rpc;
      logic [15:0] e_addr;
      logic        e_vld;
      logic [15:0] e_pc;
   } vec_t;

   vec_t vq[$];

   initial begin
      // stall, redirect, redirect_pc | expected imem_addr, instr_valid, instr_pc
      vq.push_back('{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000});
      vq.push_back('{1'b0, 1'b0, 16'h0000, 16'h0002, 1'b0, 16'h0000});
      vq.push_back('{1'b0, 1'b0, 16'h0000, 16'h0004, 1'b1, 16'h0000});
      vq.push_back('{1'b0, 1'b0, 16'h0000, 16'h0006, 1'b1, 16'h0002});
      vq.push_back('{1'b1, 1'b0, 16'h0000, 16'h0008, 1'b1, 16'h0004});
      vq.push_back('{1'b1, 1'b0, 16'h0000, 16'h0008, 1'b1, 16'h0004});
      vq.push_back('{1'b1, 1'b0, 16'h0000, 16'h0008, 1'b1, 16'h0004});
      vq.push_back('{1'b0, 1'b0, 16'h0000, 16'h0008, 1'b1, 16'h0004});
      vq.push_back('{1'b0, 1'b0, 16'h0000, 16'h000A, 1'b1, 16'h0006});
      vq.push_back('{1'b0, 1'b0, 16'h0000, 16'h000C, 1'b1, 16'h0008});
      vq.push_back('{1'b1, 1'b0, 16'h0000, 16'h000E, 1'b1, 16'h000A});
      vq.push_back('{1'b1, 1'b1, 16'h0040, 16'h000E, 1'b1, 16'h000A});
      vq.push_back('{1'b0, 1'b0, 16'h0000, 16'h0040, 1'b0, 16'h0000});
      vq.push_back('{1'b0, 1'b0, 16'h0000, 16'h0042, 1'b0, 16'h0000});
      vq.push_back('{1'b0, 1'b0, 16'h0000, 16'h0044, 1'b1, 16'h0040});
      vq.push_back('{1'b0, 1'b1, 16'h0080, 16'h0046, 1'b1, 16'h0042});
      vq.push_back('{1'b1, 1'b0, 16'h0000, 16'h0080, 1'b0, 16'h0000});
      vq.push_back('{1'b1, 1'b0, 16'h0000, 16'h0082, 1'b0, 16'h0000});
      vq.push_back('{1'b1, 1'b0, 16'h0000, 16'h0084, 1'b1, 16'h0080});
      vq.push_back('{1'b0, 1'b0, 16'h0000, 16'h0084, 1'b1, 16'h0080});
      vq.push_back('{1'b0, 1'b0, 16'h0000, 16'h0086, 1'b1, 16'h0082});
      vq.push_back('{1'b0, 1'b0, 16'h0000, 16'h0088, 1'b1, 16'h0084});

      // Reset values while rst is held
      step();
      step();
      chk("rst_addr", imem_addr, 16'h0000);
      chk("rst_addr2", imem_addr2, 16'hFFFC);
      chk("rst_instr", instr, 16'h0000);
      chk("rst_instr_pc", instr_pc, 16'h0000);
      chk("rst_valid", {15'd0, instr_valid}, 16'd0);
      chk("rst_halted", {15'd0, halted}, 16'd0);
      rst = 1'b0;

      // Main table run
      for (int i = 0; i < vq.size(); i++) begin
         chk($sformatf("v%0d_addr", i), imem_addr, vq[i].e_addr);
         chk($sformatf("v%0d_valid", i), {15'd0, instr_valid}, {15'd0, vq[i].e_vld});
         chk($sformatf("v%0d_halted", i), {15'd0, halted}, 16'd0);
         if (vq[i].e_vld) begin
            chk($sformatf("v%0d_pc", i), instr_pc, vq[i].e_pc);
            chk($sformatf("v%0d_instr", i), instr, mem_word(vq[i].e_pc, 1'b0));
         end
         if (i >= 2 && i <= 4) begin
            chk($sformatf("wrap%0d_valid", i), {15'd0, instr_valid2}, 16'd1);
            chk($sformatf("wrap%0d_pc", i), instr_pc2, 16'(16'hFFFC + 16'((i - 2) * 2)));
         end
`ifdef FETCH_PERF_EN
         if (i == 5) chk("wrap_count", fcount2, 16'd3);
`endif
         stall       = vq[i].stall;
         redirect    = vq[i].redir;
         redirect_pc = vq[i].rpc;
         step();
      end
      stall = 1'b0;
      redirect = 1'b0;
`ifdef FETCH_PERF_EN
      chk("main_count", fcount, 16'd9);
`endif

      // Reset asserted while in HOLD
      stall = 1'b1;
      step();
      chk("hold_valid", {15'd0, instr_valid}, 16'd1);
      chk("hold_pc", instr_pc, 16'h0086);
      rst = 1'b1;
      #1;
      chk("rsthold_valid", {15'd0, instr_valid}, 16'd0);
      chk("rsthold_addr", imem_addr, 16'h0000);
      chk("rsthold_instr_pc", instr_pc, 16'h0000);
      step();
      chk("rsthold_valid2", {15'd0, instr_valid}, 16'd0);
      stall = 1'b0;
      halt_en = 1'b1;
      rst = 1'b0;

      // Halt word at address 6, then redirect to 0 restarts
      chk("h_c0_addr", imem_addr, 16'h0000);
      for (int c = 0; c < 5; c++) step();
      chk("h_c5_valid", {15'd0, instr_valid}, 16'd1);
      chk("h_c5_pc", instr_pc, 16'h0006);
      chk("h_c5_instr", instr, 16'hF000);
      chk("h_c5_addr", imem_addr, 16'h000A);
      step();
      chk("h_c6_halted", {15'd0, halted}, 16'd1);
      chk("h_c6_valid", {15'd0, instr_valid}, 16'd0);
      chk("h_c6_addr", imem_addr, 16'h000A);
      step();
      step();
      chk("h_c8_halted", {15'd0, halted}, 16'd1);
      chk("h_c8_addr", imem_addr, 16'h000A);
      redirect = 1'b1;
      redirect_pc = 16'h0000;
      halt_en = 1'b0;
      step();
      redirect = 1'b0;
      chk("h_c9_halted", {15'd0, halted}, 16'd0);
      chk("h_c9_addr", imem_addr, 16'h0000);
      chk("h_c9_valid", {15'd0, instr_valid}, 16'd0);
      step();
      step();
      chk("h_c11_valid", {15'd0, instr_valid}, 16'd1);
      chk("h_c11_pc", instr_pc, 16'h0000);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
